// File: rtl/spi_pkg.sv
// spi_pkg: shared width default, synchronizer depth and FSM states
// for the SPI LED receiver.
package spi_pkg;
   localparam int DEFAULT_WIDTH = 8;
   localparam int SYNC_DEPTH = 2;
   typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer plus one edge-detect flop.
// level is the synchronized input; rise/fall are single-cycle strobes.
module spi_sync_edge
   import spi_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
)(
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);
   logic [SYNC_DEPTH-1:0] sync;
   logic last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= {SYNC_DEPTH{RST_VAL}};
         last <= RST_VAL;
      end else begin
         sync <= {sync[SYNC_DEPTH-2:0], d};
         last <= sync[SYNC_DEPTH-1];
      end
   end

   assign level = sync[SYNC_DEPTH-1];
   assign rise  = level & ~last;
   assign fall  = ~level & last;
endmodule

// File: rtl/spi_led_receiver.sv
// spi_led_receiver: mode-0 SPI slave committing frames behind valid/ready.
// Define SPI_RX_ECHO_EN to return the last committed frame instead of tx_data.
module spi_led_receiver
   import spi_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int LED_WIDTH = 6
)(
   input  logic                 sys_clk,
   input  logic                 rst,
   input  logic                 cs,
   input  logic                 sclk,
   input  logic                 mosi,
   output logic                 miso,
   input  logic [WIDTH-1:0]     tx_data,
   output logic [WIDTH-1:0]     rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic [LED_WIDTH-1:0] led
);
   localparam int CW = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] FULL = CW'(WIDTH);
   localparam logic [CW-1:0] SAT = CW'(WIDTH + 1);

   state_t state, state_nx;
   logic cs_level, cs_rise, cs_fall;
   logic sclk_level, sclk_rise, sclk_fall;
   logic [SYNC_DEPTH-1:0] mosi_q;
   logic [WIDTH-1:0] rx_sr, tx_sr, tx_load;
   logic [CW-1:0] cnt;
   logic start, shifting, take, drop, bad;

   spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
      .clk(sys_clk), .rst(rst), .d(cs),
      .level(cs_level), .rise(cs_rise), .fall(cs_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
      .clk(sys_clk), .rst(rst), .d(sclk),
      .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
   );

   // Same depth as the level path so mosi lines up with sclk_rise
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) mosi_q <= '0;
      else     mosi_q <= {mosi_q[SYNC_DEPTH-2:0], mosi};
   end

`ifdef SPI_RX_ECHO_EN
   assign tx_load = rx_data;
`else
   assign tx_load = tx_data;
`endif

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      start    = 1'b0;
      shifting = 1'b0;
      take     = 1'b0;
      drop     = 1'b0;
      bad      = 1'b0;
      unique case (state)
         IDLE: begin
            if (cs_fall) begin
               start    = 1'b1;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            if (cs_rise) state_nx = CHECK;
            else         shifting = 1'b1;
         end
         CHECK: begin
            state_nx = IDLE;
            if (cnt != FULL)                bad  = 1'b1;
            else if (rx_valid && !rx_ready) drop = 1'b1;
            else                            take = 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         rx_sr     <= '0;
         tx_sr     <= '0;
         cnt       <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= bad;
         overrun   <= drop;
         if (take) begin
            rx_data  <= rx_sr;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
         if (start) begin
            cnt   <= '0;
            tx_sr <= tx_load;
         end else if (shifting) begin
            if (sclk_rise && sclk_level) begin
               rx_sr <= {rx_sr[WIDTH-2:0], mosi_q[SYNC_DEPTH-1]};
               if (cnt != SAT) cnt <= cnt + CW'(1);
            end
            if (sclk_fall) tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
         end
      end
   end

   assign miso = (state == IDLE || cs_level) ? 1'bz : tx_sr[WIDTH-1];
   assign led  = rx_data[LED_WIDTH-1:0];
endmodule

// File: doc/spi_led_receiver.md
# spi_led_receiver

SPI slave stage sitting directly downstream of the LED-pattern SPI master. It receives WIDTH-bit frames on cs/sclk/mosi, buffers one completed frame behind a valid/ready handshake, and drives the lower LED_WIDTH bits of the last accepted frame onto its own LED bank. It returns a byte on miso in the same frame. All SPI inputs are oversampled in the sys_clk domain; sclk must run at ≤ sys_clk/4.

## Interface
- WIDTH, 8, frame length in bits, MSB first
- LED_WIDTH, 6, LEDs driven; must be ≤ WIDTH
- sys_clk  in  1  single clock; all logic on its rising edge
- rst  in  1  reset, asynchronous and active-high
- cs  in  1  chip select from master, active-low
- sclk  in  1  SPI clock, idle low (mode 0)
- mosi  in  1  master→slave data
- miso  out  1  slave→master data; 1'bz while synchronized cs is high
- tx_data  in  WIDTH  byte to return; captured at frame start
- rx_data  out  WIDTH  last committed frame; stable while rx_valid=1
- rx_valid  out  1  committed frame pending
- rx_ready  in  1  consumer accepts rx_data when rx_valid & rx_ready
- frame_err  out  1  one-cycle pulse: frame ended with bit count ≠ WIDTH
- overrun  out  1  one-cycle pulse: good frame dropped because rx_valid still high
- led  out  LED_WIDTH  = last committed rx_data[LED_WIDTH-1:0]

## Operation
- cs, sclk, mosi each pass through a 2-flop synchronizer, then a third flop for edge detect; mosi is delayed identically so it stays aligned with sclk.
- FSM states: IDLE, SHIFT, CHECK.
- IDLE: miso = z. On synced cs falling edge → SHIFT; clear bit counter; load tx_data into tx shift register; drive tx MSB on miso.
- SHIFT: on each synced sclk rising edge, shift synced mosi into rx shift register LSB; counter += 1, saturating at WIDTH+1 (width $clog2(WIDTH+2)). On each synced sclk falling edge, shift tx register left; miso = new MSB. On synced cs rising edge → CHECK.
- CHECK (one cycle): counter == WIDTH and rx_valid=0 → rx_data, led ← rx shift register, rx_valid ← 1. counter == WIDTH and rx_valid=1 → overrun pulse, data dropped, rx_data/led unchanged. Counter ≠ WIDTH (short or long) → frame_err pulse, nothing committed. Then → IDLE.
- Handshake: rx_valid clears on the cycle after rx_valid & rx_ready. If CHECK commits in the same cycle a handshake completes, the new frame commits and rx_valid stays 1. The handshake takes effect first; no overrun is raised.
- sclk edges while cs is high are ignored.
- Reset (any time, including mid-frame): state IDLE, shift registers and counter 0, rx_data 0, rx_valid 0, frame_err 0, overrun 0, led 0, miso z. Synchronizer flops reset to cs=1, sclk=0, mosi=0.

## Timing
- Input edge → detection: seen on the 2nd sys_clk edge after the edge that first samples the new level; the FSM acts on that 2nd edge.
- cs rising → rx_valid/led update or frame_err/overrun pulse: on the 3rd sys_clk rising edge.
- cs falling → miso driven with tx_data MSB: by the 3rd sys_clk edge. Master must allow ≥ 3 sys_clk before its first sclk rise.
- sclk falling → next miso bit: by the 3rd sys_clk edge.
- frame_err and overrun are exactly one sys_clk wide.
- Throughput: one frame per cs cycle. cs high time ≥ 4 sys_clk.

## Configuration
- SPI_RX_ECHO_EN defined: tx shift register loads the current rx_data at frame start instead of tx_data. The master reads back the previously committed frame; tx_data is ignored. After reset this is 0.
- Not defined: tx_data is loaded as above.

## Structure
- Shared package spi_pkg: default WIDTH, FSM state typedef (IDLE/SHIFT/CHECK), synchronizer depth constant (2).
- One sub-module: spi_sync_edge. 2-flop synchronizer plus edge detect, with parameterized reset value; outputs level, rise, fall. Instantiated for cs and sclk; mosi uses the level output only.

## Test plan
- Reset: hold rst=1 mid-activity → led=0, rx_valid=0, frame_err=0, overrun=0, miso=z.
- Frame 0xA5, sclk = sys_clk/8, rx_ready=1 → rx_data=0xA5, rx_valid high 1 cycle, led=6'h25, rising on the 3rd edge after cs rises.
- tx_data=0x3C (echo off) with mosi frame 0x00 → master captures 0x3C MSB first. With SPI_RX_ECHO_EN, send 0x5A then 0x00 → second readback = 0x5A.
- 5-bit frame, then cs high → one frame_err pulse, rx_valid=0, led unchanged. Repeat with 9 bits → same.
- rx_ready=0; frames 0x11 then 0x22 → rx_data=0x11, one overrun pulse on second. Raise rx_ready → rx_valid clears; next frame 0x33 commits.
- rst asserted after 4 bits of a frame, then released → all outputs at reset values. Next full frame 0x81 → rx_data=0x81, led=6'h01.
